// File: rtl/riscv_defines.sv
// riscv_defines: shared types and constants for the branch predictor.
//   cflow_mode_t : control-flow class of a resolved instruction
//   cflow_hint_t : call/return hint used to drive the return-address stack
//   btb_entry_t  : per-entry control fields (valid, mode, hint, 2-bit counter);
//                  tag and target live in parameter-sized arrays in the top
//   cnt_next()   : saturating 2-bit direction counter update
package riscv_defines;

    typedef enum logic [1:0] {
        MODE_NONE   = 2'b00,
        MODE_BRANCH = 2'b01,
        MODE_JAL    = 2'b10,
        MODE_JALR   = 2'b11
    } cflow_mode_t;

    typedef enum logic [1:0] {
        HINT_NONE = 2'b00,
        HINT_CALL = 2'b01,
        HINT_RET  = 2'b10
    } cflow_hint_t;

    localparam logic [1:0] CNT_STRONG_NT = 2'b00;
    localparam logic [1:0] CNT_WEAK_NT   = 2'b01;
    localparam logic [1:0] CNT_WEAK_T    = 2'b10;
    localparam logic [1:0] CNT_STRONG_T  = 2'b11;

    typedef struct packed {
        logic        valid;
        cflow_mode_t mode;
        cflow_hint_t hint;
        logic [1:0]  cnt;
    } btb_entry_t;

    // Saturating counter: climbs toward 2'b11 on taken, falls toward 2'b00 otherwise.
    function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        case (cnt)
            CNT_STRONG_NT: res = taken ? CNT_WEAK_NT  : CNT_STRONG_NT;
            CNT_WEAK_NT:   res = taken ? CNT_WEAK_T   : CNT_STRONG_NT;
            CNT_WEAK_T:    res = taken ? CNT_STRONG_T : CNT_WEAK_NT;
            CNT_STRONG_T:  res = taken ? CNT_STRONG_T : CNT_WEAK_T;
            default:       res = CNT_WEAK_NT;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack.
//   clk, rst_n    : clock, asynchronous active-low reset
//   push          : push push_data; when full the oldest entry is overwritten
//   pop           : pop the top entry; ignored when empty
//   push_data     : return address to push
//   top           : current top-of-stack value (meaningful when count > 0)
//   count         : occupancy, saturates at DEPTH
// push has priority if both strobes are raised in the same cycle.
module ras_stack #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [XLEN-1:0]            push_data,
    output logic [XLEN-1:0]            top,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] mem_r [DEPTH];
    logic [PW-1:0]   ptr_r;      // next free slot; top sits one below it
    logic [CW-1:0]   count_r;
    logic [PW-1:0]   ptr_inc_s;
    logic [PW-1:0]   ptr_dec_s;

    // Modulo-DEPTH pointer neighbours (DEPTH need not be a power of two).
    always_comb begin
        if (ptr_r == PW'(DEPTH - 1)) begin
            ptr_inc_s = {PW{1'b0}};
        end else begin
            ptr_inc_s = ptr_r + PW'(1'b1);
        end
        if (ptr_r == {PW{1'b0}}) begin
            ptr_dec_s = PW'(DEPTH - 1);
        end else begin
            ptr_dec_s = ptr_r - PW'(1'b1);
        end
    end

    // Stack storage, pointer and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r   <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {XLEN{1'b0}};
            end
        end else if (push) begin
            mem_r[ptr_r] <= push_data;
            ptr_r        <= ptr_inc_s;
            if (count_r != CW'(DEPTH)) begin
                count_r <= count_r + CW'(1'b1);
            end
        end else if (pop && (count_r != {CW{1'b0}})) begin
            ptr_r   <= ptr_dec_s;
            count_r <= count_r - CW'(1'b1);
        end
    end

    assign top   = mem_r[ptr_dec_s];
    assign count = count_r;

endmodule

// File: rtl/bp_btb_ras.sv
// bp_btb_ras: direct-mapped branch target buffer with optional return-address stack.
//   clk         : clock
//   start       : asynchronous active-low reset
//   pc_f        : fetch PC; pred_taken/pred_target are combinational from it
//   pred_taken  : predicted redirect
//   pred_target : predicted target, 0 when pred_taken=0
//   upd_*       : resolved control-flow update (valid, pc, mode, hint, taken, target)
//   ras_count   : return-address-stack occupancy
// Build option: define BP_RAS_EN to instantiate ras_stack; without it RET JALRs
// predict the BTB target and ras_count is tied to 0.
module bp_btb_ras
    import riscv_defines::*;
#(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 64,
    parameter int RAS_DEPTH   = 8
) (
    input  logic                           clk,
    input  logic                           start,
    input  logic [XLEN-1:0]                pc_f,
    output logic                           pred_taken,
    output logic [XLEN-1:0]                pred_target,
    input  logic                           upd_valid,
    input  logic [XLEN-1:0]                upd_pc,
    input  cflow_mode_t                    upd_mode,
    input  cflow_hint_t                    upd_hint,
    input  logic                           upd_taken,
    input  logic [XLEN-1:0]                upd_target,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count
);
    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;
    localparam int CW    = $clog2(RAS_DEPTH + 1);

    btb_entry_t       btb_meta_r [BTB_ENTRIES];
    logic [TAG_W-1:0] btb_tag_r  [BTB_ENTRIES];
    logic [XLEN-1:0]  btb_tgt_r  [BTB_ENTRIES];

    logic [IDX-1:0]   f_idx_s;
    logic [TAG_W-1:0] f_tag_s;
    btb_entry_t       f_meta_s;
    logic             f_hit_s;

    logic [IDX-1:0]   u_idx_s;
    logic [TAG_W-1:0] u_tag_s;
    btb_entry_t       u_meta_s;
    logic             u_hit_s;
    logic             btb_we_s;
    btb_entry_t       meta_nxt_s;
    logic [XLEN-1:0]  tgt_nxt_s;

    logic [XLEN-1:0]  ras_top_s;
    logic             unused_pc_lsb_s;

    assign f_idx_s  = pc_f[IDX+1:2];
    assign f_tag_s  = pc_f[XLEN-1:IDX+2];
    assign f_meta_s = btb_meta_r[f_idx_s];
    assign f_hit_s  = f_meta_s.valid && (btb_tag_r[f_idx_s] == f_tag_s);

    assign u_idx_s  = upd_pc[IDX+1:2];
    assign u_tag_s  = upd_pc[XLEN-1:IDX+2];
    assign u_meta_s = btb_meta_r[u_idx_s];
    assign u_hit_s  = u_meta_s.valid && (btb_tag_r[u_idx_s] == u_tag_s);

    // Instructions are word aligned; the low PC bits never reach the tables.
    assign unused_pc_lsb_s = ^{pc_f[1:0], upd_pc[1:0]};

    // Fetch-side prediction, purely combinational with no update bypass.
    always_comb begin
        pred_taken  = 1'b0;
        pred_target = {XLEN{1'b0}};
        if (f_hit_s) begin
            case (f_meta_s.mode)
                MODE_BRANCH: begin
                    if (f_meta_s.cnt[1]) begin
                        pred_taken  = 1'b1;
                        pred_target = btb_tgt_r[f_idx_s];
                    end else begin
                        pred_taken  = 1'b0;
                        pred_target = {XLEN{1'b0}};
                    end
                end
                MODE_JAL: begin
                    pred_taken  = 1'b1;
                    pred_target = btb_tgt_r[f_idx_s];
                end
                MODE_JALR: begin
                    pred_taken = 1'b1;
                    // Returns prefer the stack; an empty stack falls back to the BTB.
                    if ((f_meta_s.hint == HINT_RET) && (ras_count != {CW{1'b0}})) begin
                        pred_target = ras_top_s;
                    end else begin
                        pred_target = btb_tgt_r[f_idx_s];
                    end
                end
                default: begin
                    pred_taken  = 1'b0;
                    pred_target = {XLEN{1'b0}};
                end
            endcase
        end else begin
            pred_taken  = 1'b0;
            pred_target = {XLEN{1'b0}};
        end
    end

    // Next contents of the indexed entry: refresh on hit, allocate on miss.
    always_comb begin
        btb_we_s   = 1'b0;
        meta_nxt_s = u_meta_s;
        tgt_nxt_s  = btb_tgt_r[u_idx_s];
        if (upd_valid && (upd_mode != MODE_NONE)) begin
            if (u_hit_s) begin
                btb_we_s        = 1'b1;
                meta_nxt_s.mode = upd_mode;
                meta_nxt_s.hint = upd_hint;
                if (upd_mode == MODE_BRANCH) begin
                    meta_nxt_s.cnt = cnt_next(u_meta_s.cnt, upd_taken);
                end else begin
                    meta_nxt_s.cnt = u_meta_s.cnt;
                end
                if (upd_taken) begin
                    tgt_nxt_s = upd_target;
                end else begin
                    tgt_nxt_s = btb_tgt_r[u_idx_s];
                end
            end else if ((upd_mode != MODE_BRANCH) || upd_taken) begin
                // Not-taken branches never allocate: they would only predict not-taken.
                btb_we_s         = 1'b1;
                meta_nxt_s.valid = 1'b1;
                meta_nxt_s.mode  = upd_mode;
                meta_nxt_s.hint  = upd_hint;
                meta_nxt_s.cnt   = CNT_WEAK_T;
                tgt_nxt_s        = upd_target;
            end else begin
                btb_we_s = 1'b0;
            end
        end else begin
            btb_we_s = 1'b0;
        end
    end

    // BTB storage; reset clears every entry to invalid / weakly not-taken.
    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_meta_r[i] <= '{valid: 1'b0, mode: MODE_NONE, hint: HINT_NONE, cnt: CNT_WEAK_NT};
                btb_tag_r[i]  <= {TAG_W{1'b0}};
                btb_tgt_r[i]  <= {XLEN{1'b0}};
            end
        end else if (btb_we_s) begin
            btb_meta_r[u_idx_s] <= meta_nxt_s;
            btb_tag_r[u_idx_s]  <= u_tag_s;
            btb_tgt_r[u_idx_s]  <= tgt_nxt_s;
        end
    end

`ifdef BP_RAS_EN
    localparam logic [XLEN-1:0] RET_OFS = XLEN'(3'd4);

    logic ras_push_s;
    logic ras_pop_s;

    // The call/return hint drives the stack independently of the BTB write.
    assign ras_push_s = upd_valid && (upd_hint == HINT_CALL);
    assign ras_pop_s  = upd_valid && (upd_hint == HINT_RET);

    ras_stack #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (start),
        .push      (ras_push_s),
        .pop       (ras_pop_s),
        .push_data (upd_pc + RET_OFS),
        .top       (ras_top_s),
        .count     (ras_count)
    );
`else
    assign ras_top_s = {XLEN{1'b0}};
    assign ras_count = {CW{1'b0}};
`endif

endmodule
